// File: rtl/sram_word_ctrl.sv
// MEM-stage bridge: one WORD_W-bit access is split into WORD_W/SRAM_DW async-SRAM beats.
// Optional last-read tag bypass is enabled by defining SRAM_CTRL_RDHIT_EN.
module sram_word_ctrl #(
  parameter int unsigned WORD_W      = 32,
  parameter int unsigned SRAM_DW     = 16,
  parameter int unsigned SRAM_AW     = 18,
  parameter int unsigned WAIT_CYC    = 2,
  parameter int unsigned RECOVER_CYC = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic                rd_en,
  input  logic [31:0]         address,
  input  logic [WORD_W-1:0]   writeData,
  output logic [WORD_W-1:0]   readData,
  output logic                ready,
  inout  wire  [SRAM_DW-1:0]  SRAM_DQ,
  output logic [SRAM_AW-1:0]  SRAM_ADDR,
  output logic                SRAM_WE_N,
  output logic                SRAM_CE_N,
  output logic                SRAM_OE_N,
  output logic                SRAM_UB_N,
  output logic                SRAM_LB_N
);

  localparam int unsigned BEATS = WORD_W / SRAM_DW;
  localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned CW    = $clog2(WAIT_CYC);
  localparam int unsigned RW    = (RECOVER_CYC > 1) ? $clog2(RECOVER_CYC) : 1;

  localparam logic [BW-1:0] B_LAST = BW'(BEATS - 1);
  localparam logic [CW-1:0] C_LAST = CW'(WAIT_CYC - 1);
  localparam logic [RW-1:0] R_LAST = RW'((RECOVER_CYC > 0) ? RECOVER_CYC - 1 : 0);

  typedef enum logic [2:0] {IDLE, WR, RD, RECOVER, DONE} state_t;

  state_t              state;
  logic [BW-1:0]       b;
  logic [CW-1:0]       c;
  logic [RW-1:0]       r;
  logic                dq_oe;
  logic [SRAM_DW-1:0]  dq_out;

`ifdef SRAM_CTRL_RDHIT_EN
  logic                tag_valid;
  logic [31:0]         tag_addr;
  logic                rd_op;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      b        <= '0;
      c        <= '0;
      r        <= '0;
      readData <= '0;
`ifdef SRAM_CTRL_RDHIT_EN
      tag_valid <= 1'b0;
      tag_addr  <= '0;
      rd_op     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          b <= '0;
          c <= '0;
          r <= '0;
          if (wr_en) begin
            state <= WR;
`ifdef SRAM_CTRL_RDHIT_EN
            tag_valid <= 1'b0;
            rd_op     <= 1'b0;
`endif
          end else if (rd_en) begin
`ifdef SRAM_CTRL_RDHIT_EN
            rd_op <= 1'b1;
            // Same word as the last completed read: readData already holds it.
            if (tag_valid && address == tag_addr) state <= DONE;
            else                                  state <= RD;
`else
            state <= RD;
`endif
          end
        end
        WR, RD: begin
          if (state == RD && c == C_LAST)
            readData[b*SRAM_DW +: SRAM_DW] <= SRAM_DQ;
          if (c == C_LAST) begin
            c <= '0;
            if (b == B_LAST) begin
              b     <= '0;
              state <= (RECOVER_CYC == 0) ? DONE : RECOVER;
            end else begin
              b <= b + 1'b1;
            end
          end else begin
            c <= c + 1'b1;
          end
        end
        RECOVER: begin
          if (r == R_LAST) begin
            r     <= '0;
            state <= DONE;
          end else begin
            r <= r + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
`ifdef SRAM_CTRL_RDHIT_EN
          if (rd_op) begin
            tag_valid <= 1'b1;
            tag_addr  <= address;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Pin decode depends only on state/b/c (plus held address/data), never on wr_en/rd_en.
  always_comb begin
    SRAM_ADDR = '0;
    SRAM_WE_N = 1'b1;
    dq_oe     = 1'b0;
    dq_out    = writeData[b*SRAM_DW +: SRAM_DW];
    if (state == WR || state == RD)
      SRAM_ADDR = SRAM_AW'(address * BEATS + 32'(b));
    if (state == WR) begin
      dq_oe     = 1'b1;
      SRAM_WE_N = (c == C_LAST);
    end
  end

  always_comb begin
    ready = 1'b0;
    if (state == IDLE)      ready = ~(wr_en | rd_en);
    else if (state == DONE) ready = 1'b1;
  end

  assign SRAM_DQ   = dq_oe ? dq_out : 'z;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;

endmodule

// File: tb/tb_sram_word_ctrl.sv
// Bench for sram_word_ctrl: default 32/16 instance plus a 64-bit, WAIT_CYC=3, no-recovery instance,
// each attached to a small behavioural SRAM; expectations come from a word-level reference model.
module tb_sram_word_ctrl;

  localparam int BEATS0 = 2, WAIT0 = 2, REC0 = 2;
  localparam int LAT0   = 1 + BEATS0 * WAIT0 + REC0;
  localparam int LAT1   = 1 + 4 * 3 + 0;
`ifdef SRAM_CTRL_RDHIT_EN
  localparam bit RDHIT = 1'b1;
`else
  localparam bit RDHIT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // default instance
  logic        wr_en, rd_en, ready;
  logic [31:0] address, write_data, read_data;
  wire  [15:0] sram_dq;
  logic [17:0] sram_addr;
  logic        we_n, ce_n, oe_n, ub_n, lb_n;

  // wide instance
  logic        wr_en1, rd_en1, ready1;
  logic [31:0] address1;
  logic [63:0] write_data1, read_data1;
  wire  [15:0] sram_dq1;
  logic [17:0] sram_addr1;
  logic        we_n1, ce_n1, oe_n1, ub_n1, lb_n1;

  sram_word_ctrl u_dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address),
    .writeData(write_data), .readData(read_data), .ready(ready), .SRAM_DQ(sram_dq),
    .SRAM_ADDR(sram_addr), .SRAM_WE_N(we_n), .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n),
    .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n)
  );

  sram_word_ctrl #(.WORD_W(64), .SRAM_DW(16), .SRAM_AW(18), .WAIT_CYC(3), .RECOVER_CYC(0)) u_wide (
    .clk(clk), .rst(rst), .wr_en(wr_en1), .rd_en(rd_en1), .address(address1),
    .writeData(write_data1), .readData(read_data1), .ready(ready1), .SRAM_DQ(sram_dq1),
    .SRAM_ADDR(sram_addr1), .SRAM_WE_N(we_n1), .SRAM_CE_N(ce_n1), .SRAM_OE_N(oe_n1),
    .SRAM_UB_N(ub_n1), .SRAM_LB_N(lb_n1)
  );

  // behavioural async SRAMs (OE_N tied low; bench enables read drive only during read transactions)
  logic [15:0] mem0 [0:1023];
  logic [15:0] mem1 [0:63];
  logic        mem_drive0 = 1'b0, mem_drive1 = 1'b0;
  logic [15:0] mem_rd0, mem_rd1;
  logic        pl_en0 = 1'b0, pl_en1 = 1'b0;
  logic [9:0]  pl_a0 = '0;
  logic [5:0]  pl_a1 = '0;
  logic [15:0] pl_d0 = '0, pl_d1 = '0;

  always_comb mem_rd0 = mem0[sram_addr[9:0]];
  always_comb mem_rd1 = mem1[sram_addr1[5:0]];
  assign sram_dq  = mem_drive0 ? mem_rd0 : 'z;
  assign sram_dq1 = mem_drive1 ? mem_rd1 : 'z;

  always @(posedge clk) begin
    if (pl_en0)     mem0[pl_a0] <= pl_d0;
    else if (!we_n) mem0[sram_addr[9:0]] <= sram_dq;
    if (pl_en1)      mem1[pl_a1] <= pl_d1;
    else if (!we_n1) mem1[sram_addr1[5:0]] <= sram_dq1;
  end

  // word-level reference model
  logic [31:0] ref_word  [0:255];
  bit          ref_known [0:255];
  bit          tag_v = 1'b0;
  logic [31:0] tag_a = '0;
  logic [31:0] last_rd = '0;

  // per-cycle trace of the default instance
  logic [17:0] t_addr [0:63];
  logic        t_we   [0:63];
  logic [15:0] t_dq   [0:63];

  task automatic run0(input bit w, input bit r, input logic [31:0] a, input logic [31:0] wd,
                      output int lat);
    @(negedge clk);
    wr_en = w; rd_en = r; address = a; write_data = wd;
    mem_drive0 = r && !w;
    lat = -1;
    for (int k = 0; k < 40; k++) begin
      #1;
      t_addr[k] = sram_addr; t_we[k] = we_n; t_dq[k] = sram_dq;
      if (ready) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
    wr_en = 1'b0; rd_en = 1'b0; mem_drive0 = 1'b0;
  endtask

  task automatic preload0(input logic [31:0] a, input logic [31:0] w);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      pl_en0 = 1'b1; pl_a0 = 10'(a * 2 + 32'(i)); pl_d0 = w[i*16 +: 16];
    end
    @(negedge clk);
    pl_en0 = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    wr_en = 1'b0; rd_en = 1'b0; address = '0; write_data = '0;
    wr_en1 = 1'b0; rd_en1 = 1'b0; address1 = '0; write_data1 = '0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (ready !== 1'b1)   begin errors++; $display("FAIL reset_ready got %b want 1", ready); end
    checks++; if (we_n !== 1'b1)    begin errors++; $display("FAIL reset_we_n got %b want 1", we_n); end
    checks++; if (sram_addr !== '0) begin errors++; $display("FAIL reset_addr got %0h want 0", sram_addr); end
    checks++; if (read_data !== '0) begin errors++; $display("FAIL reset_rdata got %h want 0", read_data); end
    checks++; if ({ce_n, oe_n, ub_n, lb_n, ce_n1, oe_n1, ub_n1, lb_n1} !== 8'h00)
      begin errors++; $display("FAIL reset_ties got %b want 00000000", {ce_n, oe_n, ub_n, lb_n, ce_n1, oe_n1, ub_n1, lb_n1}); end
    checks++; if (read_data1 !== '0 || we_n1 !== 1'b1)
      begin errors++; $display("FAIL reset_wide got rdata=%h we_n=%b want 0/1", read_data1, we_n1); end
    @(negedge clk);
    rst = 1'b0;
    tag_v = 1'b0; last_rd = '0;
  endtask

  task automatic test_write_deadbeef;
    int lat;
    logic [31:0] d;
    d = 32'hDEADBEEF;
    run0(1'b1, 1'b0, 32'd5, d, lat);
    checks++; if (lat !== LAT0) begin errors++; $display("FAIL wr_latency got %0d want %0d", lat, LAT0); end
    for (int k = 0; k <= lat && k < 40; k++) begin
      if (k >= 1 && k <= BEATS0 * WAIT0) begin
        int beat, cyc;
        beat = (k - 1) / WAIT0; cyc = (k - 1) % WAIT0;
        checks++; if (t_addr[k] !== 18'(10 + beat))
          begin errors++; $display("FAIL wr_addr c%0d got %0d want %0d", k, t_addr[k], 10 + beat); end
        checks++; if (t_we[k] !== (cyc == WAIT0 - 1))
          begin errors++; $display("FAIL wr_we_n c%0d got %b want %b", k, t_we[k], cyc == WAIT0 - 1); end
        checks++; if (t_dq[k] !== d[beat*16 +: 16])
          begin errors++; $display("FAIL wr_dq c%0d got %h want %h", k, t_dq[k], d[beat*16 +: 16]); end
      end else begin
        checks++; if (t_we[k] !== 1'b1) begin errors++; $display("FAIL wr_we_idle c%0d got %b want 1", k, t_we[k]); end
      end
    end
    @(negedge clk);
    checks++; if (mem0[10] !== 16'hBEEF || mem0[11] !== 16'hDEAD)
      begin errors++; $display("FAIL wr_mem got %h_%h want dead_beef", mem0[11], mem0[10]); end
    ref_word[5] = d; ref_known[5] = 1'b1; tag_v = 1'b0;
  endtask

  task automatic test_read;
    int lat;
    run0(1'b0, 1'b1, 32'd5, 32'h0, lat);
    checks++; if (lat !== LAT0) begin errors++; $display("FAIL rd_latency got %0d want %0d", lat, LAT0); end
    checks++; if (read_data !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data got %h want deadbeef", read_data); end
    for (int k = 0; k <= lat && k < 40; k++) begin
      checks++; if (t_we[k] !== 1'b1) begin errors++; $display("FAIL rd_we_n c%0d got %b want 1", k, t_we[k]); end
      if (k >= 1 && k <= BEATS0 * WAIT0) begin
        checks++; if (t_addr[k] !== 18'(10 + (k - 1) / WAIT0))
          begin errors++; $display("FAIL rd_addr c%0d got %0d want %0d", k, t_addr[k], 10 + (k - 1) / WAIT0); end
      end
    end
    tag_v = 1'b1; tag_a = 32'd5; last_rd = 32'hDEADBEEF;
  endtask

  task automatic test_rdhit;
    int lat;
    logic [31:0] d;
    run0(1'b0, 1'b1, 32'd5, 32'h0, lat);
    if (RDHIT) begin
      checks++; if (lat !== 1) begin errors++; $display("FAIL hit_latency got %0d want 1", lat); end
      for (int k = 0; k <= lat && k < 40; k++) begin
        checks++; if (t_addr[k] !== '0) begin errors++; $display("FAIL hit_addr c%0d got %0d want 0", k, t_addr[k]); end
      end
    end else begin
      checks++; if (lat !== LAT0) begin errors++; $display("FAIL rerd_latency got %0d want %0d", lat, LAT0); end
    end
    checks++; if (read_data !== 32'hDEADBEEF) begin errors++; $display("FAIL rerd_data got %h want deadbeef", read_data); end
    d = $urandom;
    run0(1'b1, 1'b0, 32'd9, d, lat);
    ref_word[9] = d; ref_known[9] = 1'b1; tag_v = 1'b0;
    checks++; if (lat !== LAT0) begin errors++; $display("FAIL wr9_latency got %0d want %0d", lat, LAT0); end
    run0(1'b0, 1'b1, 32'd5, 32'h0, lat);
    checks++; if (lat !== LAT0) begin errors++; $display("FAIL miss_latency got %0d want %0d", lat, LAT0); end
    checks++; if (read_data !== 32'hDEADBEEF) begin errors++; $display("FAIL miss_data got %h want deadbeef", read_data); end
    tag_v = 1'b1; tag_a = 32'd5; last_rd = 32'hDEADBEEF;
  endtask

  task automatic test_both;
    int lat;
    run0(1'b1, 1'b1, 32'd3, 32'h12345678, lat);
    checks++; if (lat !== LAT0) begin errors++; $display("FAIL both_latency got %0d want %0d", lat, LAT0); end
    checks++; if (t_addr[1] !== 18'd6 || t_addr[3] !== 18'd7)
      begin errors++; $display("FAIL both_addr got %0d,%0d want 6,7", t_addr[1], t_addr[3]); end
    checks++; if (t_we[1] !== 1'b0 || t_we[3] !== 1'b0)
      begin errors++; $display("FAIL both_we_n got %b,%b want 0,0", t_we[1], t_we[3]); end
    checks++; if (read_data !== last_rd) begin errors++; $display("FAIL both_rdata got %h want %h", read_data, last_rd); end
    ref_word[3] = 32'h12345678; ref_known[3] = 1'b1; tag_v = 1'b0;
    run0(1'b0, 1'b1, 32'd3, 32'h0, lat);
    checks++; if (read_data !== 32'h12345678) begin errors++; $display("FAIL both_readback got %h want 12345678", read_data); end
    tag_v = 1'b1; tag_a = 32'd3; last_rd = 32'h12345678;
  endtask

  task automatic test_reset_mid_write;
    int lat;
    logic [31:0] d;
    @(negedge clk);
    wr_en = 1'b1; address = 32'd4; write_data = $urandom;
    @(negedge clk);
    #1;
    checks++; if (we_n !== 1'b0) begin errors++; $display("FAIL mid_pre_we_n got %b want 0", we_n); end
    rst = 1'b1;
    #1;
    checks++; if (we_n !== 1'b1)    begin errors++; $display("FAIL mid_we_n got %b want 1", we_n); end
    checks++; if (sram_addr !== '0) begin errors++; $display("FAIL mid_addr got %0d want 0", sram_addr); end
    checks++; if (read_data !== '0) begin errors++; $display("FAIL mid_rdata got %h want 0", read_data); end
    wr_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tag_v = 1'b0; last_rd = '0;
    d = $urandom;
    run0(1'b1, 1'b0, 32'd4, d, lat);
    checks++; if (lat !== LAT0) begin errors++; $display("FAIL post_wr_latency got %0d want %0d", lat, LAT0); end
    ref_word[4] = d; ref_known[4] = 1'b1;
    run0(1'b0, 1'b1, 32'd4, 32'h0, lat);
    checks++; if (read_data !== d) begin errors++; $display("FAIL post_rd_data got %h want %h", read_data, d); end
    tag_v = 1'b1; tag_a = 32'd4; last_rd = d;
  endtask

  task automatic test_random;
    int lat, exp_lat;
    logic [31:0] a, d;
    for (int n = 0; n < 30; n++) begin
      a = $urandom_range(0, 15);
      if ($urandom_range(0, 2) == 0) begin
        d = $urandom;
        run0(1'b1, 1'b0, a, d, lat);
        checks++; if (lat !== LAT0) begin errors++; $display("FAIL rnd_wr_lat n%0d got %0d want %0d", n, lat, LAT0); end
        ref_word[a] = d; ref_known[a] = 1'b1; tag_v = 1'b0;
      end else begin
        if (!ref_known[a]) begin
          d = $urandom;
          preload0(a, d);
          ref_word[a] = d; ref_known[a] = 1'b1;
        end
        exp_lat = (RDHIT && tag_v && tag_a == a) ? 1 : LAT0;
        run0(1'b0, 1'b1, a, 32'h0, lat);
        checks++; if (lat !== exp_lat) begin errors++; $display("FAIL rnd_rd_lat n%0d got %0d want %0d", n, lat, exp_lat); end
        checks++; if (read_data !== ref_word[a])
          begin errors++; $display("FAIL rnd_rd_data n%0d a%0d got %h want %h", n, a, read_data, ref_word[a]); end
        tag_v = 1'b1; tag_a = a; last_rd = ref_word[a];
      end
    end
  endtask

  task automatic test_wide;
    int lat;
    logic [63:0] w;
    logic [17:0] ta [0:63];
    logic        tw [0:63];
    w = {$urandom, $urandom};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      pl_en1 = 1'b1; pl_a1 = 6'(8 + i); pl_d1 = w[i*16 +: 16];
    end
    @(negedge clk);
    pl_en1 = 1'b0;
    rd_en1 = 1'b1; address1 = 32'd2; mem_drive1 = 1'b1;
    lat = -1;
    for (int k = 0; k < 40; k++) begin
      #1;
      ta[k] = sram_addr1; tw[k] = we_n1;
      if (ready1) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
    rd_en1 = 1'b0; mem_drive1 = 1'b0;
    checks++; if (lat !== LAT1) begin errors++; $display("FAIL wide_latency got %0d want %0d", lat, LAT1); end
    for (int k = 0; k <= lat && k < 40; k++) begin
      checks++; if (tw[k] !== 1'b1) begin errors++; $display("FAIL wide_we_n c%0d got %b want 1", k, tw[k]); end
      if (k >= 1 && k <= 12) begin
        checks++; if (ta[k] !== 18'(8 + (k - 1) / 3))
          begin errors++; $display("FAIL wide_addr c%0d got %0d want %0d", k, ta[k], 8 + (k - 1) / 3); end
      end
    end
    checks++; if (read_data1 !== w) begin errors++; $display("FAIL wide_data got %h want %h", read_data1, w); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      ref_word[i] = '0;
      ref_known[i] = 1'b0;
    end
    test_reset;
    test_write_deadbeef;
    test_read;
    test_rdhit;
    test_both;
    test_reset_mid_write;
    test_random;
    test_wide;
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
